// File: rtl/ppu_pipe_pkg.sv
// ============================================================================
// ppu_pipe_pkg : shared types and codes for the PPU hazard scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package ppu_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] dest;
    logic       rf_en;
    logic       load;
    logic       mem_en;
  } shadow_t;

  localparam shadow_t SHADOW_NOP = '0;

  // Entry will write register r with a value consumers may depend on
  function automatic logic stage_writes(shadow_t e, logic [4:0] r);
    return e.rf_en && (e.dest != REG_ZERO) && (e.dest == r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppu_hazard_scheduler_if.sv
// ============================================================================
// ppu_hazard_scheduler_if : ID-stage request fields and scheduler controls
// Rev 1.0
// ============================================================================
`default_nettype none

interface ppu_hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_dest;
  logic             id_rf_enable;
  logic             id_load_instr;
  logic             id_mem_enable;
  logic             mem_ready;
  logic             pc_le;
  logic             if_id_le;
  logic             id_nop_insert;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_rf_enable, id_load_instr, id_mem_enable, mem_ready,
    input  pc_le, if_id_le, id_nop_insert, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_rf_enable, id_load_instr, id_mem_enable, mem_ready,
    output pc_le, if_id_le, id_nop_insert, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ppu_fwd_select.sv
// ============================================================================
// ppu_fwd_select : one operand's forwarding source, priority EX > MEM > WB
// Rev 1.0
// ============================================================================
`default_nettype none

module ppu_fwd_select
  import ppu_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  shadow_t    ex_e,
  input  shadow_t    mem_e,
  input  shadow_t    wb_e,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (uses) begin
      // A load in EX has no data yet; the load-use stall covers that case
      if (stage_writes(ex_e, src) && !ex_e.load) begin
        sel = FWD_EX;
      end else if (stage_writes(mem_e, src)) begin
        sel = FWD_MEM;
      end else if (stage_writes(wb_e, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ppu_hazard_scheduler.sv
// ============================================================================
// ppu_hazard_scheduler : load-use stall, memory freeze and forwarding control
// Rev 1.0
// ============================================================================
`default_nettype none

module ppu_hazard_scheduler
  import ppu_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ppu_hazard_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  shadow_t          ex_q, mem_q, wb_q;
  shadow_t          ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shadow_t          id_entry;
  logic             freeze;
  logic             load_use;
  logic [1:0]       fwd_a, fwd_b;

  assign id_entry = '{dest:   bus.id_dest,
                      rf_en:  bus.id_rf_enable,
                      load:   bus.id_load_instr,
                      mem_en: bus.id_mem_enable};

  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;

    // The freeze outranks load-use; the hazard is re-evaluated after release
    freeze   = !bus.mem_ready && ((state_q == ST_MEM_WAIT) || mem_q.mem_en);
    load_use = !freeze && bus.id_valid && ex_q.load &&
               ((bus.id_uses_rs && stage_writes(ex_q, bus.id_rs)) ||
                (bus.id_uses_rt && stage_writes(ex_q, bus.id_rt)));

    state_d = freeze ? ST_MEM_WAIT : ST_RUN;

    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (load_use || !bus.id_valid) ? SHADOW_NOP : id_entry;
    end

    if (load_use && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      ex_q    <= SHADOW_NOP;
      mem_q   <= SHADOW_NOP;
      wb_q    <= SHADOW_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  ppu_fwd_select u_fwd_a (
    .src   (bus.id_rs),
    .uses  (bus.id_uses_rs),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .wb_e  (wb_q),
    .sel   (fwd_a)
  );

  ppu_fwd_select u_fwd_b (
    .src   (bus.id_rt),
    .uses  (bus.id_uses_rt),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .wb_e  (wb_q),
    .sel   (fwd_b)
  );

  // Reset drives the held-pipeline values straight through, not via flops
  assign bus.pc_le         = reset_n && !freeze && !load_use;
  assign bus.if_id_le      = reset_n && !freeze && !load_use;
  assign bus.id_nop_insert = !reset_n || load_use;
  assign bus.fwd_a_sel     = reset_n ? fwd_a : FWD_RF;
  assign bus.fwd_b_sel     = reset_n ? fwd_b : FWD_RF;
  assign bus.stall_cnt     = cnt_q;

endmodule

`default_nettype wire
